// File: rtl/l2_tlb_pkg.sv
// l2_tlb_pkg: shared FSM state type and geometry helpers for the L2 TLB search controller
package l2_tlb_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, RESP} search_state_t;
  function automatic int port_addr_width(input int set_width, input int offset_width);
    return set_width + offset_width + 1;
  endfunction
  function automatic int ignore_lsb(input int page_size);
    return $clog2(page_size);
  endfunction
endpackage

// File: rtl/l2_tlb_search_ctrl.sv
// l2_tlb_search_ctrl: walks a TLB set two entries per cycle, returns the first hit or a miss.
// Defining L2_SEARCH_PERF_CNT_EN adds saturating hit/miss/stall counters.
module l2_tlb_search_ctrl
  import l2_tlb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int PAGE_SIZE    = 4096,
  parameter int SET_WIDTH    = 5,
  parameter int OFFSET_WIDTH = 4,
  localparam int PA = port_addr_width(SET_WIDTH, OFFSET_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_rw_i,
  input  logic                    cfg_we_i,
  input  logic [PA-1:0]           cfg_waddr_i,
  output logic                    ram_we_o,
  output logic [PA-1:0]           port0_addr_o,
  output logic [PA-1:0]           port1_addr_o,
  output logic [OFFSET_WIDTH-1:0] offset_addr_d_o,
  output logic                    output_valid_o,
  output logic                    output_sent_o,
  output logic [ADDR_WIDTH-1:0]   in_addr_o,
  output logic                    rw_type_o,
  input  logic                    hit_i,
  input  logic                    master_i,
  input  logic                    multi_hit_i,
  input  logic                    prot_i,
  input  logic [PA-1:0]           hit_addr_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic                    resp_hit_o,
  output logic                    resp_master_o,
  output logic                    resp_multi_o,
  output logic                    resp_prot_o,
  output logic [PA-1:0]           resp_addr_o
`ifdef L2_SEARCH_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o,
  output logic [31:0]             stall_cnt_o
`endif
);
  localparam int IGNORE_LSB = ignore_lsb(PAGE_SIZE);
  search_state_t state;
  logic [OFFSET_WIDTH:0] cnt;
  logic issued_q;
  logic cfg_we;
  logic issue;
  logic done;
  logic [SET_WIDTH-1:0] set_idx;
  // Reset also masks the combinational outputs so everything reads 0 while held.
  assign cfg_we = cfg_we_i && rst_ni;
  assign set_idx = in_addr_o[IGNORE_LSB +: SET_WIDTH];
  assign output_valid_o = issued_q;
  always_comb begin
    issue = state == SEARCH && !cfg_we && !cnt[OFFSET_WIDTH];
    done = state == SEARCH && output_valid_o && (hit_i || offset_addr_d_o == '1);
    req_ready_o = rst_ni && state == IDLE;
    ram_we_o = cfg_we;
    port0_addr_o = cfg_we ? cfg_waddr_i : issue ? {1'b0, set_idx, cnt[OFFSET_WIDTH-1:0]} : '0;
    port1_addr_o = issue ? {1'b1, set_idx, cnt[OFFSET_WIDTH-1:0]} : '0;
    resp_valid_o = state == RESP;
    output_sent_o = state == RESP && resp_ready_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      issued_q <= 1'b0;
      offset_addr_d_o <= '0;
      in_addr_o <= '0;
      rw_type_o <= 1'b0;
      resp_hit_o <= 1'b0;
      resp_master_o <= 1'b0;
      resp_multi_o <= 1'b0;
      resp_prot_o <= 1'b0;
      resp_addr_o <= '0;
    end else begin
      // A read issued in the hit cycle is dropped; its data would never be compared.
      issued_q <= issue && !(output_valid_o && hit_i);
      if (issue) begin
        offset_addr_d_o <= cnt[OFFSET_WIDTH-1:0];
        cnt <= cnt + 1'b1;
      end
      case (state)
        IDLE: if (req_valid_i) begin
          state <= SEARCH;
          in_addr_o <= req_addr_i;
          rw_type_o <= req_rw_i;
          cnt <= '0;
        end
        SEARCH: if (done) begin
          state <= RESP;
          resp_hit_o <= hit_i;
          resp_master_o <= hit_i && master_i;
          resp_multi_o <= hit_i && multi_hit_i;
          resp_prot_o <= hit_i && prot_i;
          resp_addr_o <= hit_i ? hit_addr_i : '0;
        end
        RESP: if (resp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef L2_SEARCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (done && hit_i && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
      if (done && !hit_i && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
      if (state == SEARCH && cfg_we && !cnt[OFFSET_WIDTH] && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_l2_tlb_search_ctrl.sv
// tb_l2_tlb_search_ctrl: directed self-checking bench for l2_tlb_search_ctrl
module tb_l2_tlb_search_ctrl;
  logic clk_i = 0;
  logic rst_ni = 0;
  logic req_valid_i = 0;
  logic req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic req_rw_i = 0;
  logic cfg_we_i = 0;
  logic [9:0] cfg_waddr_i = '0;
  logic ram_we_o;
  logic [9:0] port0_addr_o, port1_addr_o;
  logic [3:0] offset_addr_d_o;
  logic output_valid_o, output_sent_o;
  logic [31:0] in_addr_o;
  logic rw_type_o;
  logic hit_i, master_i, multi_hit_i, prot_i;
  logic [9:0] hit_addr_i;
  logic resp_valid_o;
  logic resp_ready_i = 0;
  logic resp_hit_o, resp_master_o, resp_multi_o, resp_prot_o;
  logic [9:0] resp_addr_o;
  logic hit_en = 0, master_v = 0, multi_v = 0, prot_v = 0;
  logic [3:0] hit_off = '0;
  logic [9:0] hit_addr_v = '0;
  int st_c = 0, st_n = 0;
  logic [9:0] p0_log [64];
  logic [9:0] p1_log [64];
  logic we_log [64];
  logic ov_log [64];
  int tot = 0, bad = 0;

  l2_tlb_search_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i), .req_rw_i(req_rw_i),
    .cfg_we_i(cfg_we_i), .cfg_waddr_i(cfg_waddr_i), .ram_we_o(ram_we_o),
    .port0_addr_o(port0_addr_o), .port1_addr_o(port1_addr_o), .offset_addr_d_o(offset_addr_d_o),
    .output_valid_o(output_valid_o), .output_sent_o(output_sent_o),
    .in_addr_o(in_addr_o), .rw_type_o(rw_type_o),
    .hit_i(hit_i), .master_i(master_i), .multi_hit_i(multi_hit_i), .prot_i(prot_i), .hit_addr_i(hit_addr_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit_o), .resp_master_o(resp_master_o), .resp_multi_o(resp_multi_o),
    .resp_prot_o(resp_prot_o), .resp_addr_o(resp_addr_o)
  );

  always #5 clk_i = ~clk_i;

  // Check stage stand-in: a hit is reported when the chosen offset's data returns.
  always_comb begin
    hit_i = hit_en && output_valid_o && offset_addr_d_o == hit_off;
    master_i = master_v;
    multi_hit_i = multi_v;
    prot_i = prot_v;
    hit_addr_i = hit_addr_v;
  end

  task automatic send_req(input logic [31:0] a, input logic rw);
    req_valid_i = 1; req_addr_i = a; req_rw_i = rw;
    @(posedge clk_i); #1;
    req_valid_i = 0;
  endtask

  task automatic wait_resp(output int rc);
    rc = 0;
    for (int c = 1; c < 64; c++) begin
      cfg_we_i = (c >= st_c && c < st_c + st_n);
      @(negedge clk_i);
      p0_log[c] = port0_addr_o; p1_log[c] = port1_addr_o; we_log[c] = ram_we_o; ov_log[c] = output_valid_o;
      if (resp_valid_o) begin rc = c; break; end
      @(posedge clk_i); #1;
    end
    cfg_we_i = 0;
  endtask

  task automatic finish_resp(output logic sent);
    resp_ready_i = 1; #1;
    sent = output_sent_o;
    @(posedge clk_i); #1;
    resp_ready_i = 0;
  endtask

  task automatic test_reset();
    #2;
    tot++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready_o); end
    tot++; if ({resp_valid_o, output_valid_o, output_sent_o, ram_we_o} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {resp_valid_o, output_valid_o, output_sent_o, ram_we_o}); end
    tot++; if ({port0_addr_o, port1_addr_o, resp_addr_o} !== 30'b0) begin bad++; $display("FAIL rst_addrs got=%h exp=0", {port0_addr_o, port1_addr_o, resp_addr_o}); end
    @(negedge clk_i); rst_ni = 1;
    @(posedge clk_i); #1;
    tot++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%b exp=1", req_ready_o); end
  endtask

  task automatic test_hit();
    int rc; logic sent;
    hit_en = 1; hit_off = 4'd3; hit_addr_v = 10'h053; master_v = 1; multi_v = 0; prot_v = 0; st_n = 0;
    send_req(32'h0000_5ABC, 0);
    wait_resp(rc);
    tot++; if (rc !== 6) begin bad++; $display("FAIL hit_latency got=%0d exp=6", rc); end
    tot++; if (p0_log[4] !== 10'h053) begin bad++; $display("FAIL hit_port0_c4 got=%h exp=053", p0_log[4]); end
    tot++; if (p1_log[4] !== 10'h253) begin bad++; $display("FAIL hit_port1_c4 got=%h exp=253", p1_log[4]); end
    tot++; if ({resp_hit_o, resp_master_o, resp_multi_o, resp_prot_o} !== 4'b1100) begin bad++; $display("FAIL hit_flags got=%b exp=1100", {resp_hit_o, resp_master_o, resp_multi_o, resp_prot_o}); end
    tot++; if (resp_addr_o !== 10'h053) begin bad++; $display("FAIL hit_addr got=%h exp=053", resp_addr_o); end
    tot++; if ({in_addr_o, rw_type_o} !== {32'h0000_5ABC, 1'b0}) begin bad++; $display("FAIL hit_latched got=%h/%b exp=00005abc/0", in_addr_o, rw_type_o); end
    finish_resp(sent);
    tot++; if (sent !== 1'b1) begin bad++; $display("FAIL hit_sent got=%b exp=1", sent); end
  endtask

  task automatic test_miss();
    int rc, n; logic sent;
    hit_en = 0; hit_addr_v = 10'h155; master_v = 1; multi_v = 1; prot_v = 1; st_n = 0;
    send_req(32'h0001_F000, 0);
    wait_resp(rc);
    n = 0;
    for (int c = 1; c <= 17; c++) n += int'(ov_log[c]);
    tot++; if (rc !== 18) begin bad++; $display("FAIL miss_latency got=%0d exp=18", rc); end
    tot++; if (n !== 16) begin bad++; $display("FAIL miss_reads got=%0d exp=16", n); end
    tot++; if ({p0_log[1], p0_log[16], p0_log[17]} !== {10'h1F0, 10'h1FF, 10'h000}) begin bad++; $display("FAIL miss_port0_walk got=%h/%h/%h exp=1f0/1ff/000", p0_log[1], p0_log[16], p0_log[17]); end
    tot++; if ({resp_hit_o, resp_master_o, resp_multi_o, resp_prot_o} !== 4'b0000) begin bad++; $display("FAIL miss_flags got=%b exp=0000", {resp_hit_o, resp_master_o, resp_multi_o, resp_prot_o}); end
    tot++; if (resp_addr_o !== 10'h000) begin bad++; $display("FAIL miss_addr got=%h exp=000", resp_addr_o); end
    finish_resp(sent);
    tot++; if (sent !== 1'b1) begin bad++; $display("FAIL miss_sent got=%b exp=1", sent); end
    tot++; if ({output_sent_o, resp_valid_o, req_ready_o} !== 3'b001) begin bad++; $display("FAIL miss_after got=%b exp=001", {output_sent_o, resp_valid_o, req_ready_o}); end
  endtask

  task automatic test_cfg_stall();
    int rc; logic sent;
    hit_en = 1; hit_off = 4'd6; hit_addr_v = 10'h236; master_v = 0; multi_v = 0; prot_v = 0;
    cfg_waddr_i = 10'h3AA; st_c = 5; st_n = 2;
    send_req(32'h0000_3000, 0);
    wait_resp(rc);
    st_n = 0;
    tot++; if ({we_log[5], we_log[6], we_log[7]} !== 3'b110) begin bad++; $display("FAIL stall_we got=%b exp=110", {we_log[5], we_log[6], we_log[7]}); end
    tot++; if ({p0_log[5], p0_log[6]} !== {10'h3AA, 10'h3AA}) begin bad++; $display("FAIL stall_waddr got=%h/%h exp=3aa/3aa", p0_log[5], p0_log[6]); end
    tot++; if (p0_log[7] !== 10'h034) begin bad++; $display("FAIL stall_resume got=%h exp=034", p0_log[7]); end
    tot++; if ({ov_log[6], ov_log[7], ov_log[8]} !== 3'b001) begin bad++; $display("FAIL stall_bubble got=%b exp=001", {ov_log[6], ov_log[7], ov_log[8]}); end
    tot++; if (rc !== 11) begin bad++; $display("FAIL stall_latency got=%0d exp=11", rc); end
    tot++; if ({resp_hit_o, resp_addr_o} !== {1'b1, 10'h236}) begin bad++; $display("FAIL stall_resp got=%b/%h exp=1/236", resp_hit_o, resp_addr_o); end
    finish_resp(sent);
    tot++; if (sent !== 1'b1) begin bad++; $display("FAIL stall_sent got=%b exp=1", sent); end
  endtask

  task automatic test_back_to_back();
    int rc, sends; logic sent;
    hit_en = 1; hit_off = 4'd0; hit_addr_v = 10'h010; master_v = 0; multi_v = 0; prot_v = 0;
    send_req(32'h0000_1000, 0);
    wait_resp(rc);
    tot++; if (rc !== 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", rc); end
    req_valid_i = 1; req_addr_i = 32'h0000_2000; req_rw_i = 0;
    sends = 0;
    for (int i = 0; i < 5; i++) begin
      tot++; if ({resp_valid_o, resp_hit_o, resp_addr_o, req_ready_o} !== {1'b1, 1'b1, 10'h010, 1'b0}) begin bad++; $display("FAIL hold_stable_%0d got=%b/%b/%h/%b exp=1/1/010/0", i, resp_valid_o, resp_hit_o, resp_addr_o, req_ready_o); end
      sends += int'(output_sent_o);
      @(negedge clk_i);
    end
    tot++; if ({sends, in_addr_o} !== {32'd0, 32'h0000_1000}) begin bad++; $display("FAIL hold_no_accept got=%0d/%h exp=0/00001000", sends, in_addr_o); end
    resp_ready_i = 1; #1;
    tot++; if ({output_sent_o, req_ready_o} !== 2'b10) begin bad++; $display("FAIL hs_cycle got=%b exp=10", {output_sent_o, req_ready_o}); end
    @(posedge clk_i); #1;
    resp_ready_i = 0;
    tot++; if ({req_ready_o, resp_valid_o, output_sent_o} !== 3'b100) begin bad++; $display("FAIL hs_next got=%b exp=100", {req_ready_o, resp_valid_o, output_sent_o}); end
    @(posedge clk_i); #1;
    req_valid_i = 0;
    tot++; if ({in_addr_o, req_ready_o} !== {32'h0000_2000, 1'b0}) begin bad++; $display("FAIL b2b_accept got=%h/%b exp=00002000/0", in_addr_o, req_ready_o); end
    wait_resp(rc);
    tot++; if (rc !== 3) begin bad++; $display("FAIL b2b_second got=%0d exp=3", rc); end
    finish_resp(sent);
    tot++; if (sent !== 1'b1) begin bad++; $display("FAIL b2b_sent got=%b exp=1", sent); end
  endtask

  task automatic test_write_multi_prot();
    int rc; logic sent;
    hit_en = 1; hit_off = 4'd0; hit_addr_v = 10'h040; master_v = 0; multi_v = 1; prot_v = 1;
    send_req(32'h0000_4000, 1);
    wait_resp(rc);
    tot++; if (rc !== 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", rc); end
    tot++; if ({rw_type_o, resp_hit_o, resp_master_o, resp_multi_o, resp_prot_o} !== 5'b11011) begin bad++; $display("FAIL wr_flags got=%b exp=11011", {rw_type_o, resp_hit_o, resp_master_o, resp_multi_o, resp_prot_o}); end
    tot++; if (resp_addr_o !== 10'h040) begin bad++; $display("FAIL wr_addr got=%h exp=040", resp_addr_o); end
    finish_resp(sent);
    tot++; if (sent !== 1'b1) begin bad++; $display("FAIL wr_sent got=%b exp=1", sent); end
  endtask

  task automatic test_async_reset();
    int sends;
    hit_en = 0;
    send_req(32'h0000_6000, 0);
    repeat (6) begin @(posedge clk_i); #1; end
    tot++; if ({output_valid_o, offset_addr_d_o, req_ready_o} !== {1'b1, 4'd5, 1'b0}) begin bad++; $display("FAIL pre_rst got=%b/%h/%b exp=1/5/0", output_valid_o, offset_addr_d_o, req_ready_o); end
    cfg_we_i = 1; cfg_waddr_i = 10'h2C3; #1;
    rst_ni = 0; #1;
    tot++; if ({output_valid_o, offset_addr_d_o, ram_we_o, req_ready_o, resp_valid_o, output_sent_o} !== 9'b0) begin bad++; $display("FAIL arst_flags got=%b/%h/%b/%b/%b/%b exp=all 0", output_valid_o, offset_addr_d_o, ram_we_o, req_ready_o, resp_valid_o, output_sent_o); end
    tot++; if ({port0_addr_o, port1_addr_o, in_addr_o} !== 52'b0) begin bad++; $display("FAIL arst_addrs got=%h/%h/%h exp=0", port0_addr_o, port1_addr_o, in_addr_o); end
    cfg_we_i = 0;
    @(negedge clk_i); rst_ni = 1;
    sends = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk_i); #1; sends += int'(output_sent_o); end
    tot++; if ({sends, req_ready_o, resp_valid_o, output_valid_o} !== {32'd0, 3'b100}) begin bad++; $display("FAIL post_rst got=%0d/%b/%b/%b exp=0/1/0/0", sends, req_ready_o, resp_valid_o, output_valid_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_cfg_stall();
    test_back_to_back();
    test_write_multi_prot();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
